// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: op codes, MMIO register map, STATUS layout.
package dmem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // MMIO registers are selected by word index (byte offset / 4).
    localparam logic [1:0] REG_CONSOLE  = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_MTIME_LO = 2'd2;
    localparam logic [1:0] REG_MTIME_HI = 2'd3;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_MIS     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam logic [31:0] DEF_RAM_BASE  = 32'h8010_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'hA000_0000;

endpackage

// File: rtl/console_fifo.sv
// Circular FIFO with wrap-bit pointers; head reads as zero while empty.
// Simultaneous push and pop are both accepted even when full.
module console_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // A write landing during reset is harmless: the pointers are flushed anyway.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word RAM with load extension, plus MMIO console FIFO,
// STATUS and a 64-bit cycle counter with a tear-free high-half shadow.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 16384,
    parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
    parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemdatain,
    input  logic [2:0]  dmemop,
    input  logic        dmemwe,
    input  logic        dmemre,
    output logic [31:0] dmemdataout,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [31:0]       ram_off;
    logic              in_ram, in_mmio;
    logic [RAM_AW-1:0] word_idx;
    logic [1:0]        lane, reg_sel;
    logic              rd_misalign, wr_misalign;
    logic [3:0]        wr_be;
    logic [31:0]       wr_dat, ram_word, ram_rd, mmio_rd, status;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              ram_we, push, pop, fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count;
    logic [63:0]       mtime_q, mtime_d;
    logic [31:0]       shadow_q, shadow_d;
    logic              ovf_q, ovf_d, mis_q, mis_d;

    assign ram_off  = dmemaddr - RAM_BASE;
    assign in_ram   = (ram_off[31:RAM_AW+2] == '0);
    assign word_idx = ram_off[RAM_AW+1:2];
    assign lane     = ram_off[1:0];
    assign in_mmio  = (dmemaddr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel  = dmemaddr[3:2];

    always_comb begin
        rd_misalign = 1'b0;
        wr_misalign = 1'b0;
        wr_be       = 4'b0000;
        wr_dat      = dmemdatain;
        case (dmemop)
            OP_B, OP_BU: rd_misalign = 1'b0;
            OP_H, OP_HU: rd_misalign = lane[0];
            default:     rd_misalign = |lane;
        endcase
        case (dmemop)
            OP_B: begin
                wr_be  = 4'b0001 << lane;
                wr_dat = {4{dmemdatain[7:0]}};
            end
            OP_H: begin
                wr_misalign = lane[0];
                wr_be       = lane[0] ? 4'b0000 : (lane[1] ? 4'b1100 : 4'b0011);
                wr_dat      = {2{dmemdatain[15:0]}};
            end
            OP_W: begin
                wr_misalign = |lane;
                wr_be       = (|lane) ? 4'b0000 : 4'b1111;
            end
            default: wr_be = 4'b0000;
        endcase
    end

    assign ram_word = ram_q[word_idx];
    assign rd_byte  = ram_word[{lane, 3'b000} +: 8];
    assign rd_half  = lane[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        case (dmemop)
            OP_B:    ram_rd = {{24{rd_byte[7]}}, rd_byte};
            OP_BU:   ram_rd = {24'h0, rd_byte};
            OP_H:    ram_rd = {{16{rd_half[15]}}, rd_half};
            OP_HU:   ram_rd = {16'h0, rd_half};
            default: ram_rd = ram_word;
        endcase
        if (rd_misalign) ram_rd = '0;
    end

    always_comb begin
        status             = '0;
        status[ST_EMPTY]   = fifo_empty;
        status[ST_FULL]    = fifo_full;
        status[ST_OVF]     = ovf_q;
        status[ST_MIS]     = mis_q;
        status[ST_CNT_LSB +: 4] = 4'(fifo_count);
        case (reg_sel)
            REG_STATUS:   mmio_rd = status;
            REG_MTIME_LO: mmio_rd = mtime_q[31:0];
            REG_MTIME_HI: mmio_rd = shadow_q;
            default:      mmio_rd = '0;
        endcase
    end

    assign dmemdataout = in_ram ? ram_rd : (in_mmio ? mmio_rd : '0);

    // Gating with rst keeps a store that coincides with reset from landing.
    assign ram_we = dmemwe & in_ram & ~rst;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) ram_q[word_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

    assign push = dmemwe & in_mmio & (reg_sel == REG_CONSOLE);
    assign pop  = console_valid & console_ready;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (dmemdatain[7:0]),
        .pop_i      (pop),
        .head_o     (console_data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    assign console_valid = ~fifo_empty;

    always_comb begin
        mtime_d  = mtime_q + 64'd1;
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        mis_d    = mis_q;
        if (dmemre && in_mmio && reg_sel == REG_MTIME_LO) shadow_d = mtime_q[63:32];
        if (dmemwe && in_mmio && reg_sel == REG_STATUS) begin
            ovf_d = 1'b0;
            mis_d = 1'b0;
        end
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if (in_ram && ((dmemwe && wr_misalign) || (dmemre && rd_misalign))) mis_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q  <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            mis_q    <= mis_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes/extension, misalign, console FIFO, mtime shadow, reset.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] RB = 32'h8010_0000;
    localparam logic [31:0] MB = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmemaddr, dmemdatain, dmemdataout;
    logic [2:0]  dmemop;
    logic        dmemwe, dmemre;
    logic [7:0]  console_data;
    logic        console_valid, console_ready;

    int checks = 0;
    int passes = 0;

    dmem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .dmemaddr      (dmemaddr),
        .dmemdatain    (dmemdatain),
        .dmemop        (dmemop),
        .dmemwe        (dmemwe),
        .dmemre        (dmemre),
        .dmemdataout   (dmemdataout),
        .console_data  (console_data),
        .console_valid (console_valid),
        .console_ready (console_ready)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        @(negedge clk);
        dmemaddr = a; dmemdatain = d; dmemop = op; dmemwe = 1'b1; dmemre = 1'b0;
        @(posedge clk);
        #1 dmemwe = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] op, input logic re);
        @(negedge clk);
        dmemaddr = a; dmemop = op; dmemwe = 1'b0; dmemre = re;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; dmemaddr = '0; dmemdatain = '0; dmemop = OP_W;
        dmemwe = 1'b0; dmemre = 1'b0; console_ready = 1'b0;
        repeat (2) @(negedge clk);
        dmemaddr = MB + 32'h4; #1;
        checks++; if (dmemdataout !== 32'h1) $display("FAIL reset_status got %h want %h", dmemdataout, 32'h1); else passes++;
        checks++; if (console_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", console_valid); else passes++;
        checks++; if (console_data !== 8'h00) $display("FAIL reset_data got %h want 00", console_data); else passes++;
        dmemaddr = MB + 32'h8; #1;
        checks++; if (dmemdataout !== 32'h0) $display("FAIL reset_mtime got %h want 0", dmemdataout); else passes++;
        rst = 1'b0;
        rd(MB + 32'h8, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'd1) $display("FAIL mtime_first got %h want 1", dmemdataout); else passes++;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (dmemdataout !== 32'd4) $display("FAIL mtime_count got %h want 4", dmemdataout); else passes++;
    endtask

    task automatic test_ram_lanes;
        wr(RB, 32'h8765_4321, OP_W);
        rd(RB + 3, OP_B, 1'b0);
        checks++; if (dmemdataout !== 32'hFFFF_FF87) $display("FAIL lb_p3 got %h want FFFFFF87", dmemdataout); else passes++;
        rd(RB + 3, OP_BU, 1'b0);
        checks++; if (dmemdataout !== 32'h0000_0087) $display("FAIL lbu_p3 got %h want 00000087", dmemdataout); else passes++;
        rd(RB + 2, OP_H, 1'b0);
        checks++; if (dmemdataout !== 32'hFFFF_8765) $display("FAIL lh_p2 got %h want FFFF8765", dmemdataout); else passes++;
        rd(RB + 2, OP_HU, 1'b0);
        checks++; if (dmemdataout !== 32'h0000_8765) $display("FAIL lhu_p2 got %h want 00008765", dmemdataout); else passes++;
        rd(RB, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h8765_4321) $display("FAIL lw_p0 got %h want 87654321", dmemdataout); else passes++;
    endtask

    task automatic test_byte_half;
        wr(RB + 4, 32'h1122_3344, OP_W);
        wr(RB + 5, 32'h1234_56AA, OP_B);
        rd(RB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h1122_AA44) $display("FAIL sb_lw got %h want 1122AA44", dmemdataout); else passes++;
        rd(RB + 5, OP_B, 1'b0);
        checks++; if (dmemdataout !== 32'hFFFF_FFAA) $display("FAIL sb_lb got %h want FFFFFFAA", dmemdataout); else passes++;
        wr(RB + 6, 32'h5555_BEEF, OP_H);
        rd(RB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'hBEEF_AA44) $display("FAIL sh_lw got %h want BEEFAA44", dmemdataout); else passes++;
        rd(RB + 6, OP_HU, 1'b0);
        checks++; if (dmemdataout !== 32'h0000_BEEF) $display("FAIL sh_lhu got %h want 0000BEEF", dmemdataout); else passes++;
    endtask

    task automatic test_misalign;
        wr(RB + 1, 32'h0000_1234, OP_H);
        rd(RB, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h8765_4321) $display("FAIL mis_sh_ram got %h want 87654321", dmemdataout); else passes++;
        rd(MB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h9) $display("FAIL mis_sh_status got %h want 9", dmemdataout); else passes++;
        wr(MB + 4, 32'h0, OP_W);
        rd(MB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h1) $display("FAIL mis_clear got %h want 1", dmemdataout); else passes++;
        rd(RB + 2, OP_W, 1'b1);
        checks++; if (dmemdataout !== 32'h0) $display("FAIL mis_lw_data got %h want 0", dmemdataout); else passes++;
        @(posedge clk); #1 dmemre = 1'b0;
        rd(MB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h9) $display("FAIL mis_lw_status got %h want 9", dmemdataout); else passes++;
        wr(MB + 4, 32'h0, OP_W);
        rd(32'h0000_1000, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h0) $display("FAIL unmapped got %h want 0", dmemdataout); else passes++;
    endtask

    task automatic test_console_overflow;
        console_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(MB, 32'h41 + i, OP_W);
        rd(MB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h806) $display("FAIL ovf_status got %h want 806", dmemdataout); else passes++;
        rd(MB, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h0) $display("FAIL console_read got %h want 0", dmemdataout); else passes++;
        @(negedge clk); console_ready = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (console_valid !== 1'b1 || console_data !== 8'(8'h41 + i))
                $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, console_valid, console_data, 8'(8'h41 + i));
            else passes++;
            @(negedge clk); #1;
        end
        checks++; if (console_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", console_valid); else passes++;
        console_ready = 1'b0;
        wr(MB + 4, 32'h0, OP_W);
        rd(MB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h1) $display("FAIL ovf_clear got %h want 1", dmemdataout); else passes++;
    endtask

    task automatic test_push_pop_full;
        console_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(MB, 32'h10 + i, OP_W);
        @(negedge clk);
        console_ready = 1'b1; dmemaddr = MB; dmemdatain = 32'h18; dmemop = OP_W; dmemwe = 1'b1;
        @(posedge clk);
        #1 dmemwe = 1'b0; console_ready = 1'b0;
        rd(MB + 4, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h802) $display("FAIL pp_status got %h want 802", dmemdataout); else passes++;
        @(negedge clk); console_ready = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (console_valid !== 1'b1 || console_data !== 8'(8'h11 + i))
                $display("FAIL pp_drain_%0d got v=%b d=%h want v=1 d=%h", i, console_valid, console_data, 8'(8'h11 + i));
            else passes++;
            @(negedge clk); #1;
        end
        checks++; if (console_valid !== 1'b0) $display("FAIL pp_empty got %b want 0", console_valid); else passes++;
        console_ready = 1'b0;
    endtask

    task automatic test_mtime_wrap;
        @(negedge clk);
        force dut.mtime_q = 64'h0000_0000_FFFF_FFFF;
        dmemaddr = MB + 32'h8; dmemop = OP_W; dmemwe = 1'b0; dmemre = 1'b1;
        #1;
        checks++; if (dmemdataout !== 32'hFFFF_FFFF) $display("FAIL mtime_lo got %h want FFFFFFFF", dmemdataout); else passes++;
        @(posedge clk);
        #1 release dut.mtime_q;
        dmemre = 1'b0;
        rd(MB + 32'hC, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'h0) $display("FAIL mtime_hi got %h want 0", dmemdataout); else passes++;
    endtask

    task automatic test_reset_midstream;
        wr(RB + 8, 32'h0BAD_F00D, OP_W);
        wr(RB + 1, 32'h0, OP_W);
        console_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(MB, 32'h61 + i, OP_W);
        @(negedge clk);
        console_ready = 1'b1;
        dmemaddr = RB + 8; dmemdatain = 32'hDEAD_BEEF; dmemop = OP_W; dmemwe = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (console_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", console_valid); else passes++;
        checks++; if (console_data !== 8'h00) $display("FAIL rstmid_data got %h want 00", console_data); else passes++;
        @(posedge clk);
        #1 dmemwe = 1'b0; console_ready = 1'b0;
        dmemaddr = MB + 32'h4; #1;
        checks++; if (dmemdataout !== 32'h1) $display("FAIL rstmid_status got %h want 1", dmemdataout); else passes++;
        dmemaddr = MB + 32'h8; #1;
        checks++; if (dmemdataout !== 32'h0) $display("FAIL rstmid_mtime got %h want 0", dmemdataout); else passes++;
        dmemaddr = RB + 8; #1;
        checks++; if (dmemdataout !== 32'h0BAD_F00D) $display("FAIL rstmid_store got %h want 0BADF00D", dmemdataout); else passes++;
        @(negedge clk);
        rst = 1'b0;
        rd(MB + 32'h8, OP_W, 1'b0);
        checks++; if (dmemdataout !== 32'd1) $display("FAIL rstmid_restart got %h want 1", dmemdataout); else passes++;
    endtask

    initial begin
        test_reset;
        test_ram_lanes;
        test_byte_half;
        test_misalign;
        test_console_overflow;
        test_push_pop_full;
        test_mtime_wrap;
        test_reset_midstream;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the CPU data-memory port. Services the single-cycle core's loads and stores against a word-organised RAM with byte/half lanes and load extension. Also decodes a small MMIO window holding a console TX FIFO, a status register and a 64-bit cycle counter. Sits directly opposite the core on the `dmem*` bus; the console side drains to the testbench/UART.

## Interface
- `RAM_WORDS`, 16384: RAM depth in 32-bit words (power of two).
- `RAM_BASE`, 32'h8010_0000: RAM window base; window size `4*RAM_WORDS`.
- `MMIO_BASE`, 32'hA000_0000: MMIO window base; window size 16 bytes.
- `FIFO_DEPTH`, 8: console FIFO entries (power of two, ≥2).
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset is asynchronous and active-high.
- `dmemaddr` in 32: byte address.
- `dmemdatain` in 32: store data, low-aligned (byte in [7:0], half in [15:0]).
- `dmemop` in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu; others are treated as w for reads and ignored for writes.
- `dmemwe` in 1: store strobe.
- `dmemre` in 1: load strobe, used only for read side effects.
- `dmemdataout` out 32: extended load data.
- `console_data` out 8: FIFO head byte.
- `console_valid` out 1: FIFO non-empty.
- `console_ready` in 1: sink accepts head this cycle.

## Operation
- RAM write: `dmemwe` in the RAM window. sb writes lane `addr[1:0]`. sh writes the half selected by `addr[1]`. sw writes the full word. Misaligned h (`addr[0]`) or w (`addr[1:0]!=0`) is dropped and sets sticky MISALIGN.
- RAM read: combinational from the array. The lane is selected by the address, then sign-extended (b/h) or zero-extended (bu/hu). A misaligned load returns 0 and sets MISALIGN at the edge if `dmemre`.
- MMIO offsets are word-aligned; accesses are full-word in effect.
  - 0x0 CONSOLE: a write pushes `dmemdatain[7:0]`. A push while full (and no pop that cycle) is dropped and sets sticky OVERFLOW. Reads return 0.
  - 0x4 STATUS: bit0 empty, bit1 full, bit2 OVERFLOW, bit3 MISALIGN, [11:8] count. Any write clears bits 2–3.
  - 0x8 MTIME_LO: returns `mtime[31:0]`. A read with `dmemre` latches `mtime[63:32]` into shadow.
  - 0xC MTIME_HI: returns the shadow. Writes to 0x8/0xC are ignored.
- `mtime` increments by 1 every cycle out of reset and wraps at 2^64.
- Unmapped address: writes ignored, reads return 0, no flags.
- FIFO pop: `console_valid & console_ready` at the edge. Push and pop in the same cycle are both accepted, including when full; count is unchanged.

## Timing
- Reset values: FIFO empty (`console_valid` 0, `console_data` 0), count 0, OVERFLOW/MISALIGN 0, mtime 0, shadow 0. `dmemdataout` follows the combinational decode. RAM contents are not reset.
- Loads have zero latency. A store takes effect at the edge, and a same-cycle read returns the pre-edge value.
- A push becomes visible on `console_valid` the cycle after the edge.
- MTIME_LO read at edge N returns the pre-edge `mtime`, and the shadow holds the matching high half. This makes a LO-then-HI pair tear-free across a 32-bit wrap.
- Reset asserted mid-transfer aborts the store, flushes the FIFO and clears the flags. The release edge is treated as an ordinary edge.

## Structure
- `dmem_pkg`: dmemop encodings, MMIO offsets, STATUS bit positions, default bases.
- Sub-module `console_fifo`: parameterised circular FIFO with push/pop/full/empty/count, using wrap-around pointers with an extra MSB.
- Top: address decode, lane/extension logic, RAM array, mtime/shadow, sticky flags.

## Test plan
- sw 0x8765_4321 to 0x8010_0000, then lb/lbu at +3 → 0xFFFF_FF87 / 0x0000_0087. lh/lhu at +2 → 0xFFFF_8765 / 0x0000_8765.
- sb 0xAA to +1 over word 0x1122_3344 → lw returns 0x1122_AA44. sh 0xBEEF at +2 → 0xBEEF_AA44.
- sh to 0x8010_0001 → RAM unchanged, STATUS bit3=1. Any write to STATUS → 0.
- `console_ready`=0, write 'A'..'I' (9 bytes) → count 8, full=1, OVERFLOW=1. Raise ready → 'A'..'H' stream out, one per cycle, then `console_valid`=0.
- Full FIFO with ready=1 plus a push in the same cycle → count stays 8, the new byte is emitted last, no OVERFLOW.
- Force mtime to 0x0000_0000_FFFF_FFFF, read LO then HI next cycle → LO=0xFFFF_FFFF, HI=0 (shadow, not 1). Assert rst mid-stream → FIFO empty and mtime 0 immediately.
